// File: rtl/video_timing_generator_if.sv
// video_timing_generator_if
//   Bundles the run enable and the registered timing outputs of the video
//   timing generator so that downstream pattern/pixel stages take one port.
//   master : the generator (drives timing, samples en)
//   slave  : the consumer/controller (drives en, samples timing)
//   Signals: en, hsync, vsync, display_on, hpos, vpos, pix_stb, line_start,
//            frame_start, frame_cnt
interface video_timing_generator_if #(
    parameter int H_BITS     = 10,
    parameter int V_BITS     = 10,
    parameter int FRAME_BITS = 8
);
    logic                  en;
    logic                  hsync;
    logic                  vsync;
    logic                  display_on;
    logic [H_BITS-1:0]     hpos;
    logic [V_BITS-1:0]     vpos;
    logic                  pix_stb;
    logic                  line_start;
    logic                  frame_start;
    logic [FRAME_BITS-1:0] frame_cnt;

    modport master (
        input  en,
        output hsync, vsync, display_on, hpos, vpos,
               pix_stb, line_start, frame_start, frame_cnt
    );

    modport slave (
        output en,
        input  hsync, vsync, display_on, hpos, vpos,
               pix_stb, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/video_timing_generator.sv
// video_timing_generator
//   Parametrised VGA-class raster timing generator. A clock divider produces
//   one advance every CLK_DIV enabled clocks; each advance steps the raster
//   position and registers the position together with all its decodes, so
//   every output describes the same pixel in the same cycle.
//   Ports:
//     clk     : system clock
//     reset_n : asynchronous active-low reset
//     vif     : timing interface (master) - en in; sync, position, strobes,
//               frame counter out
module video_timing_generator #(
    parameter int H_DISPLAY    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_DISPLAY    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter bit HSYNC_ACTIVE = 1'b0,
    parameter bit VSYNC_ACTIVE = 1'b0,
    parameter int CLK_DIV      = 4,
    parameter int H_BITS       = 10,
    parameter int V_BITS       = 10,
    parameter int FRAME_BITS   = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    video_timing_generator_if.master    vif
);
    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [H_BITS-1:0] H_LAST   = H_BITS'(H_TOTAL - 1);
    localparam logic [V_BITS-1:0] V_LAST   = V_BITS'(V_TOTAL - 1);

    logic [DIV_W-1:0]      r_div;
    logic [H_BITS-1:0]     r_hpos;
    logic [V_BITS-1:0]     r_vpos;
    logic                  r_hsync;
    logic                  r_vsync;
    logic                  r_disp;
    logic                  r_pix;
    logic                  r_line;
    logic                  r_frame;
    logic [FRAME_BITS-1:0] r_fcnt;

    logic                  w_adv;
    logic                  w_hwrap;
    logic                  w_vwrap;
    logic [H_BITS-1:0]     w_hnext;
    logic [V_BITS-1:0]     w_vnext;
    logic                  w_hsync;
    logic                  w_vsync;
    logic                  w_disp;

    // Decodes are taken from the *next* position so they land in the same
    // register stage as the position they describe.
    always_comb begin
        w_adv   = vif.en && (r_div == DIV_LAST);
        w_hwrap = (r_hpos == H_LAST);
        w_vwrap = w_hwrap && (r_vpos == V_LAST);
        w_hnext = w_hwrap ? '0 : r_hpos + 1'b1;
        w_vnext = r_vpos;
        if (w_hwrap)
            w_vnext = (r_vpos == V_LAST) ? '0 : r_vpos + 1'b1;
        w_disp  = (int'(w_hnext) < H_DISPLAY) && (int'(w_vnext) < V_DISPLAY);
        w_hsync = ((int'(w_hnext) >= HS_START) && (int'(w_hnext) < HS_END))
                  ? HSYNC_ACTIVE : !HSYNC_ACTIVE;
        w_vsync = ((int'(w_vnext) >= VS_START) && (int'(w_vnext) < VS_END))
                  ? VSYNC_ACTIVE : !VSYNC_ACTIVE;
    end

    // Reset parks the raster on the last back-porch pixel, so the first
    // advance naturally enters (0,0) and raises frame_start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div   <= '0;
            r_hpos  <= H_LAST;
            r_vpos  <= V_LAST;
            r_hsync <= !HSYNC_ACTIVE;
            r_vsync <= !VSYNC_ACTIVE;
            r_disp  <= 1'b0;
            r_pix   <= 1'b0;
            r_line  <= 1'b0;
            r_frame <= 1'b0;
            r_fcnt  <= '0;
        end else begin
            if (vif.en)
                r_div <= w_adv ? '0 : r_div + 1'b1;
            // strobes are single-cycle: they drop on any non-advance edge
            r_pix   <= w_adv;
            r_line  <= w_adv && w_hwrap;
            r_frame <= w_adv && w_vwrap;
            if (w_adv) begin
                r_hpos  <= w_hnext;
                r_vpos  <= w_vnext;
                r_hsync <= w_hsync;
                r_vsync <= w_vsync;
                r_disp  <= w_disp;
                if (w_vwrap)
                    r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    assign vif.hsync       = r_hsync;
    assign vif.vsync       = r_vsync;
    assign vif.display_on  = r_disp;
    assign vif.hpos        = r_hpos;
    assign vif.vpos        = r_vpos;
    assign vif.pix_stb     = r_pix;
    assign vif.line_start  = r_line;
    assign vif.frame_start = r_frame;
    assign vif.frame_cnt   = r_fcnt;
endmodule
